asrm_interrupt_ctrl: RTL and testbench

- Parametrised interrupt controller for the ASRM core, supporting nb_int lines with fixed priority (index 0 highest).
- Each line is selectable as edge or level triggered; edge requests are held in a pending latch until serviced.
- Preemption nests up to a parametrised depth; a stack holds each return PC and its priority level.
- Sits beside the CPU: supplies the routine address and the int strobe, and returns the saved PC on retint.

---
 rtl/asrm_interrupt_ctrl_pkg.sv | 28 ++
 rtl/asrm_interrupt_ctrl_if.sv | 40 ++++
 rtl/asrm_int_stack.sv | 48 ++++
 rtl/asrm_interrupt_ctrl.sv | 128 ++++++++++++
 tb/tb_asrm_interrupt_ctrl.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/asrm_interrupt_ctrl_pkg.sv
// Shared definitions for the ASRM interrupt controller: default sizes,
// the idle-level encoding, a clog2 helper and the stack operation type.
package asrm_interrupt_ctrl_pkg;

    localparam int WORDSIZE_DEF = 16;
    localparam int NB_INT_DEF   = 8;
    localparam int DEPTH_DEF    = 8;

    // Push and pop are mutually exclusive in any cycle.
    typedef enum logic [1:0] {
        STK_HOLD = 2'd0,
        STK_PUSH = 2'd1,
        STK_POP  = 2'd2
    } stack_op_e;

    // Ceiling log2, usable in constant parameter expressions.
    function automatic int asrm_clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

    // The level value meaning "normal context, no interrupt in service".
    function automatic int int_idle(input int nb_int);
        return nb_int;
    endfunction

endpackage

// File: rtl/asrm_interrupt_ctrl_if.sv
// CPU-side bus of the interrupt controller; the controller uses the slave
// modport, the CPU (or a bench) uses the master modport.
interface asrm_interrupt_ctrl_if
    import asrm_interrupt_ctrl_pkg::*;
#(
    parameter int wordsize = WORDSIZE_DEF,
    parameter int nb_int   = NB_INT_DEF
);
    localparam int iw = asrm_clog2(nb_int);
    localparam int lw = asrm_clog2(nb_int + 1);

    logic [nb_int-1:0]   i_ext_int;
    logic [nb_int-1:0]   i_int_mask;
    logic [nb_int-1:0]   i_edge_sel;
    logic                i_rt_we;
    logic [iw-1:0]       i_rt_idx;
    logic [wordsize-1:0] i_rt_data;
    logic [wordsize-1:0] i_program_counter;
    logic                i_retint;
    logic                i_cpu_update;
    logic                o_int;
    logic [wordsize-1:0] o_out_routine;
    logic                o_ret_valid;
    logic [wordsize-1:0] o_ret_addr;
    logic [lw-1:0]       o_level;
    logic                o_overflow;

    modport master (
        output i_ext_int, i_int_mask, i_edge_sel, i_rt_we, i_rt_idx, i_rt_data,
               i_program_counter, i_retint, i_cpu_update,
        input  o_int, o_out_routine, o_ret_valid, o_ret_addr, o_level, o_overflow
    );

    modport slave (
        input  i_ext_int, i_int_mask, i_edge_sel, i_rt_we, i_rt_idx, i_rt_data,
               i_program_counter, i_retint, i_cpu_update,
        output o_int, o_out_routine, o_ret_valid, o_ret_addr, o_level, o_overflow
    );

endinterface

// File: rtl/asrm_int_stack.sv
// Return stack for nested interrupts; each entry holds {return PC, level}.
// The top entry reads as zero when the stack is empty.
module asrm_int_stack
    import asrm_interrupt_ctrl_pkg::*;
#(
    parameter int width = 20,
    parameter int depth = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [width-1:0] i_in,
    output logic [width-1:0] o_top,
    output logic             o_full,
    output logic             o_empty
);
    localparam int cw = asrm_clog2(depth + 1);
    localparam int pw = (asrm_clog2(depth) > 0) ? asrm_clog2(depth) : 1;

    logic [width-1:0] r_mem [depth];
    logic [cw-1:0]    r_count;
    logic [pw-1:0]    w_wr_idx;
    logic [pw-1:0]    w_rd_idx;

    assign w_wr_idx = pw'(r_count);
    assign w_rd_idx = pw'(r_count - cw'(1));
    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == cw'(depth));
    assign o_top    = o_empty ? '0 : r_mem[w_rd_idx];

    // Occupancy count; reset empties the stack regardless of contents.
    always_ff @(posedge clk) begin
        if (!reset)
            r_count <= '0;
        else if (i_push && !o_full)
            r_count <= r_count + cw'(1);
        else if (i_pop && !o_empty)
            r_count <= r_count - cw'(1);
    end

    // Entry storage; contents beyond the count are never observed.
    always_ff @(posedge clk) begin
        if (i_push && !o_full)
            r_mem[w_wr_idx] <= i_in;
    end

endmodule

// File: rtl/asrm_interrupt_ctrl.sv
// Fixed-priority, nestable interrupt controller for the ASRM core.
// Line 0 has the highest priority; level == nb_int means normal context.
module asrm_interrupt_ctrl
    import asrm_interrupt_ctrl_pkg::*;
#(
    parameter int wordsize = WORDSIZE_DEF,
    parameter int nb_int   = NB_INT_DEF,
    parameter int depth    = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    asrm_interrupt_ctrl_if.slave   bus
);
    localparam int iw = asrm_clog2(nb_int);
    localparam int lw = asrm_clog2(nb_int + 1);
    localparam logic [lw-1:0] LEVEL_IDLE = lw'(int_idle(nb_int));

    logic [nb_int-1:0]      r_hist;
    logic [nb_int-1:0]      r_pending;
    logic [lw-1:0]          r_level;
    logic                   r_overflow;
    logic [wordsize-1:0]    r_table [nb_int];

    logic [nb_int-1:0]      w_rise;
    logic [nb_int-1:0]      w_req;
    logic [nb_int-1:0]      w_clear;
    logic [iw-1:0]          w_target;
    logic                   w_any_req;
    logic                   w_can_pre;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_new_int;
    logic                   w_quit_int;
    stack_op_e              w_stack_op;
    logic                   w_push;
    logic                   w_pop;
    logic [wordsize+lw-1:0] w_stack_in;
    logic [wordsize+lw-1:0] w_stack_top;
    logic [lw-1:0]          w_ret_level;

    assign w_rise    = bus.i_ext_int & ~r_hist & bus.i_edge_sel;
    assign w_req     = (r_pending | (bus.i_ext_int & ~bus.i_edge_sel)) & bus.i_int_mask;
    assign w_any_req = |w_req;

    // Priority encoder: lowest requesting index wins.
    always_comb begin
        w_target = '0;
        for (int i = nb_int - 1; i >= 0; i--) begin
            if (w_req[i]) w_target = iw'(i);
        end
    end

    assign w_can_pre  = w_any_req && (lw'(w_target) < r_level);
    assign w_new_int  = bus.i_cpu_update && w_can_pre && !w_full;
    assign w_quit_int = bus.i_cpu_update && bus.i_retint && !w_new_int && !w_empty;

    // A new entry takes precedence over a return; the CPU replays retint later.
    always_comb begin
        w_stack_op = STK_HOLD;
        if (w_new_int)
            w_stack_op = STK_PUSH;
        else if (w_quit_int)
            w_stack_op = STK_POP;
    end

    assign w_push      = (w_stack_op == STK_PUSH);
    assign w_pop       = (w_stack_op == STK_POP);
    assign w_stack_in  = {bus.i_program_counter, r_level};
    assign w_ret_level = w_stack_top[lw-1:0];
    assign w_clear     = w_new_int ? (nb_int'(1) << w_target) : '0;

    assign bus.o_int         = w_new_int;
    assign bus.o_out_routine = w_any_req ? r_table[w_target] : '0;
    assign bus.o_ret_valid   = w_quit_int;
    assign bus.o_ret_addr    = w_stack_top[wordsize+lw-1:lw];
    assign bus.o_level       = r_level;
    assign bus.o_overflow    = r_overflow;

    // Edge history and pending latch; a coincident new edge beats the clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hist    <= '0;
            r_pending <= '0;
        end else begin
            r_hist    <= bus.i_ext_int;
            r_pending <= (r_pending & ~w_clear) | w_rise;
        end
    end

    // Current priority level and the sticky refused-preemption flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_level    <= LEVEL_IDLE;
            r_overflow <= 1'b0;
        end else begin
            if (w_new_int)
                r_level <= lw'(w_target);
            else if (w_quit_int)
                r_level <= w_ret_level;
            if (bus.i_cpu_update && w_can_pre && w_full)
                r_overflow <= 1'b1;
        end
    end

    // Routine address table; out-of-range indices are ignored.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < nb_int; i++) r_table[i] <= '0;
        end else if (bus.i_rt_we && (int'(bus.i_rt_idx) < nb_int)) begin
            r_table[bus.i_rt_idx] <= bus.i_rt_data;
        end
    end

    asrm_int_stack #(
        .width (wordsize + lw),
        .depth (depth)
    ) u_stack (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_in    (w_stack_in),
        .o_top   (w_stack_top),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule

// File: tb/tb_asrm_interrupt_ctrl.sv
// Directed bench for asrm_interrupt_ctrl (nb_int=8, depth=2): each step drives
// the CPU-side inputs, queues the expected outputs and checks them before the
// next rising edge.
module tb_asrm_interrupt_ctrl;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    asrm_interrupt_ctrl_if #(.wordsize(16), .nb_int(8)) bus ();

    asrm_interrupt_ctrl #(.wordsize(16), .nb_int(8), .depth(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       tag;
        logic        eInt;
        logic [15:0] eRoutine;
        logic        eRv;
        logic [15:0] eRa;
        logic [3:0]  eLevel;
        logic        eOvf;
    } exp_t;

    exp_t expQ[$];
    int total = 0;
    int bad   = 0;

    // Pop the oldest expectation and compare it with the live outputs.
    task automatic checkOutput();
        exp_t e;
        #1;
        e = expQ.pop_front();
        total++;
        assert (bus.o_int === e.eInt) else begin
            bad++; $error("FAIL %s int: observed=%0h expected=%0h", e.tag, bus.o_int, e.eInt);
        end
        total++;
        assert (bus.o_out_routine === e.eRoutine) else begin
            bad++; $error("FAIL %s routine: observed=%0h expected=%0h", e.tag, bus.o_out_routine, e.eRoutine);
        end
        total++;
        assert (bus.o_ret_valid === e.eRv) else begin
            bad++; $error("FAIL %s ret_valid: observed=%0h expected=%0h", e.tag, bus.o_ret_valid, e.eRv);
        end
        total++;
        assert (bus.o_ret_addr === e.eRa) else begin
            bad++; $error("FAIL %s ret_addr: observed=%0h expected=%0h", e.tag, bus.o_ret_addr, e.eRa);
        end
        total++;
        assert (bus.o_level === e.eLevel) else begin
            bad++; $error("FAIL %s level: observed=%0h expected=%0h", e.tag, bus.o_level, e.eLevel);
        end
        total++;
        assert (bus.o_overflow === e.eOvf) else begin
            bad++; $error("FAIL %s overflow: observed=%0h expected=%0h", e.tag, bus.o_overflow, e.eOvf);
        end
        @(negedge clk);
        #1;
    endtask

    // Drive one cycle of CPU inputs and queue what the outputs must show.
    task automatic applyStimulus(input string tag, input logic [7:0] ext, input logic upd,
                                 input logic rti, input logic [15:0] pc,
                                 input logic eInt, input logic [15:0] eRoutine, input logic eRv,
                                 input logic [15:0] eRa, input logic [3:0] eLevel, input logic eOvf);
        exp_t e;
        bus.i_ext_int         = ext;
        bus.i_cpu_update      = upd;
        bus.i_retint          = rti;
        bus.i_program_counter = pc;
        bus.i_rt_we           = 1'b0;
        e.tag = tag; e.eInt = eInt; e.eRoutine = eRoutine; e.eRv = eRv;
        e.eRa = eRa; e.eLevel = eLevel; e.eOvf = eOvf;
        expQ.push_back(e);
        checkOutput();
    endtask

    task automatic writeTable(input logic [2:0] idx, input logic [15:0] data);
        bus.i_rt_we      = 1'b1;
        bus.i_rt_idx     = idx;
        bus.i_rt_data    = data;
        bus.i_cpu_update = 1'b0;
        bus.i_retint     = 1'b0;
        @(negedge clk);
        #1;
        bus.i_rt_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset                 = 1'b0;
        bus.i_ext_int         = '0;
        bus.i_int_mask        = '0;
        bus.i_edge_sel        = 8'hFF;
        bus.i_rt_we           = 1'b0;
        bus.i_rt_idx          = '0;
        bus.i_rt_data         = '0;
        bus.i_program_counter = '0;
        bus.i_retint          = 1'b0;
        bus.i_cpu_update      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;

        applyStimulus("reset",     8'h00, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 4'd8, 0);
        reset          = 1'b1;
        bus.i_int_mask = 8'hFF;
        writeTable(3'd3, 16'h0300);
        writeTable(3'd1, 16'h0110);
        writeTable(3'd5, 16'h0500);
        writeTable(3'd2, 16'h0200);
        writeTable(3'd6, 16'h0600);
        writeTable(3'd4, 16'h0400);
        writeTable(3'd0, 16'h0010);

        // Edge entry on line 3, nested preemption by line 1, then unwind.
        applyStimulus("pulse3",    8'h08, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 4'd8, 0);
        applyStimulus("take3",     8'h00, 1, 0, 16'h0100, 1, 16'h0300, 0, 16'h0000, 4'd8, 0);
        applyStimulus("pulse1",    8'h02, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0100, 4'd3, 0);
        applyStimulus("take1",     8'h00, 1, 0, 16'h0304, 1, 16'h0110, 0, 16'h0100, 4'd3, 0);
        applyStimulus("ret1",      8'h00, 1, 1, 16'h0000, 0, 16'h0000, 1, 16'h0304, 4'd1, 0);
        applyStimulus("ret3",      8'h00, 1, 1, 16'h0000, 0, 16'h0000, 1, 16'h0100, 4'd3, 0);
        applyStimulus("idle",      8'h00, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 4'd8, 0);

        // Level-mode line 5 blocked at level 2, taken after return, dropped when released.
        bus.i_edge_sel = 8'hDF;
        applyStimulus("pulse2",    8'h04, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 4'd8, 0);
        applyStimulus("take2",     8'h00, 1, 0, 16'h0200, 1, 16'h0200, 0, 16'h0000, 4'd8, 0);
        applyStimulus("lvl5blk",   8'h20, 1, 0, 16'h0000, 0, 16'h0500, 0, 16'h0200, 4'd2, 0);
        applyStimulus("ret2",      8'h20, 1, 1, 16'h0000, 0, 16'h0500, 1, 16'h0200, 4'd2, 0);
        applyStimulus("take5",     8'h20, 1, 0, 16'h0210, 1, 16'h0500, 0, 16'h0000, 4'd8, 0);
        applyStimulus("ret5",      8'h00, 1, 1, 16'h0000, 0, 16'h0000, 1, 16'h0210, 4'd5, 0);
        applyStimulus("lvl5gone",  8'h00, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 4'd8, 0);
        bus.i_edge_sel = 8'hFF;

        // Fill the two-entry stack, refuse line 2, then retry after a return.
        applyStimulus("pulse6",    8'h40, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 4'd8, 0);
        applyStimulus("take6",     8'h00, 1, 0, 16'h1000, 1, 16'h0600, 0, 16'h0000, 4'd8, 0);
        applyStimulus("pulse4",    8'h10, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h1000, 4'd6, 0);
        applyStimulus("take4",     8'h00, 1, 0, 16'h1100, 1, 16'h0400, 0, 16'h1000, 4'd6, 0);
        applyStimulus("pulse2b",   8'h04, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h1100, 4'd4, 0);
        applyStimulus("full2",     8'h00, 1, 0, 16'h1200, 0, 16'h0200, 0, 16'h1100, 4'd4, 0);
        applyStimulus("retfull",   8'h00, 1, 1, 16'h0000, 0, 16'h0200, 1, 16'h1100, 4'd4, 1);
        applyStimulus("retry2",    8'h00, 1, 0, 16'h1300, 1, 16'h0200, 0, 16'h1000, 4'd6, 1);
        applyStimulus("ret2b",     8'h00, 1, 1, 16'h0000, 0, 16'h0000, 1, 16'h1300, 4'd2, 1);
        applyStimulus("ret6",      8'h00, 1, 1, 16'h0000, 0, 16'h0000, 1, 16'h1000, 4'd6, 1);

        // Edge on line 0 in the same cycle it is taken keeps it pending.
        applyStimulus("pulse0",    8'h01, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 4'd8, 1);
        applyStimulus("low0",      8'h00, 0, 0, 16'h0000, 0, 16'h0010, 0, 16'h0000, 4'd8, 1);
        applyStimulus("take0edge", 8'h01, 1, 0, 16'h2000, 1, 16'h0010, 0, 16'h0000, 4'd8, 1);
        applyStimulus("ret0",      8'h00, 1, 1, 16'h0000, 0, 16'h0010, 1, 16'h2000, 4'd0, 1);
        applyStimulus("retake0",   8'h00, 1, 0, 16'h2100, 1, 16'h0010, 0, 16'h0000, 4'd8, 1);
        applyStimulus("ret0b",     8'h00, 1, 1, 16'h0000, 0, 16'h0000, 1, 16'h2100, 4'd0, 1);

        // retint with nothing stacked does nothing.
        applyStimulus("retempty",  8'h00, 1, 1, 16'h0000, 0, 16'h0000, 0, 16'h0000, 4'd8, 1);
        applyStimulus("stillidle", 8'h00, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 4'd8, 1);

        // Reset while nested discards the stack and the sticky flag.
        applyStimulus("pulse3b",   8'h08, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 4'd8, 1);
        applyStimulus("take3b",    8'h00, 1, 0, 16'h3000, 1, 16'h0300, 0, 16'h0000, 4'd8, 1);
        reset = 1'b0;
        applyStimulus("inreset",   8'h00, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h3000, 4'd3, 1);
        reset = 1'b1;
        applyStimulus("postreset", 8'h00, 1, 1, 16'h0000, 0, 16'h0000, 0, 16'h0000, 4'd8, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
